// File: rtl/ahb_pkg.sv
// Shared AHB types for the bus arbiter: transfer encodings, arbiter states and
// a one-hot to index helper.
package ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [1:0] {
    PARK,
    OWN,
    LOCKED
  } arb_state_t;

  localparam int MAX_MASTERS = 16;

  // Valid only for one-hot (or zero) inputs; OR-ing the set positions is enough.
  function automatic logic [3:0] onehot2idx(input logic [MAX_MASTERS-1:0] oh);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_MASTERS; i++) begin
      if (oh[i]) idx = idx | 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// Round-robin picker: first set request after ptr, wrapping, with ptr itself last.
// Uses a doubled request vector masked to the window (ptr, ptr+N].
module ahb_rr_picker #(
  parameter int NUM_MASTERS = 4,
  parameter int MW          = (NUM_MASTERS > 2) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [MW-1:0]          ptr,
  output logic [MW-1:0]          idx,
  output logic                   any
);

  logic [2*NUM_MASTERS-1:0] dbl;
  logic [2*NUM_MASTERS-1:0] msk;
  logic [2*NUM_MASTERS-1:0] hit;

  always_comb begin
    dbl = {req, req};
    msk = '0;
    for (int i = 0; i < 2*NUM_MASTERS; i++) begin
      msk[i] = (i > int'(ptr)) && (i <= int'(ptr) + NUM_MASTERS);
    end
    hit = dbl & msk;
    any = |req;
    idx = '0;
    // Descending scan so the lowest hit position is the one that sticks.
    for (int i = 2*NUM_MASTERS-1; i >= 0; i--) begin
      if (hit[i]) idx = MW'(i % NUM_MASTERS);
    end
  end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB-lite arbiter: hands the shared slave path over only at
// transfer boundaries, honours locked sequences and bounds per-owner tenure.
module ahb_bus_arbiter
  import ahb_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0,
  parameter int MAX_TENURE     = 16,
  localparam int MW            = (NUM_MASTERS > 2) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                   hclk,
  input  logic                   hreset,
  input  logic [NUM_MASTERS-1:0] hbusreq,
  input  logic [NUM_MASTERS-1:0] hlock,
  input  logic [1:0]             htrans,
  input  logic                   hready,
  output logic [NUM_MASTERS-1:0] hgrant,
  output logic [MW-1:0]          hmaster,
  output logic                   hmastlock,
  output logic                   tenure_expired
);

  localparam int CW = $clog2(MAX_TENURE + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_TENURE);
  localparam logic [MW-1:0] DEF_IDX = MW'(DEFAULT_MASTER);

  arb_state_t state, state_nxt, eff;
  htrans_t    tr;

  // ptr always names the currently granted master.
  logic [MW-1:0]          ptr, ptr_nxt, pick, gidx;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic [NUM_MASTERS-1:0] grant_nxt;
  logic                   any, bnd, beat, rearb;

  assign tr   = htrans_t'(htrans);
  assign gidx = MW'(onehot2idx(16'(hgrant)));

  ahb_rr_picker #(
    .NUM_MASTERS (NUM_MASTERS),
    .MW          (MW)
  ) u_picker (
    .req (hbusreq),
    .ptr (ptr),
    .idx (pick),
    .any (any)
  );

  always_comb begin
    bnd  = hready && (tr != BUSY) && (tr != SEQ);
    beat = hready && (tr == NONSEQ || tr == SEQ);

    // Leaving LOCKED is resolved first so re-arbitration can follow in the same cycle.
    eff = state;
    if (state == LOCKED && bnd && !hlock[ptr]) eff = OWN;

    rearb = bnd && (eff != LOCKED) &&
            (eff == PARK || !hbusreq[ptr] || tr == IDLE || tenure_expired);

    state_nxt = eff;
    ptr_nxt   = ptr;
    if (rearb) begin
      if (any) begin
        ptr_nxt   = pick;
        state_nxt = OWN;
      end else begin
        ptr_nxt   = DEF_IDX;
        state_nxt = PARK;
      end
    end
    if (eff == OWN && state_nxt == OWN && ptr_nxt == ptr && hready && hlock[ptr])
      state_nxt = LOCKED;

    cnt_nxt = cnt;
    if (ptr_nxt != ptr)
      cnt_nxt = '0;
    else if (state != PARK && beat && cnt != CNT_MAX)
      cnt_nxt = cnt + CW'(1);

    grant_nxt          = '0;
    grant_nxt[ptr_nxt] = 1'b1;
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state          <= PARK;
      ptr            <= DEF_IDX;
      cnt            <= '0;
      hgrant         <= NUM_MASTERS'(1) << DEF_IDX;
      hmaster        <= DEF_IDX;
      hmastlock      <= 1'b0;
      tenure_expired <= 1'b0;
    end else begin
      state          <= state_nxt;
      ptr            <= ptr_nxt;
      cnt            <= cnt_nxt;
      hgrant         <= grant_nxt;
      tenure_expired <= (cnt_nxt == CNT_MAX);
      // The address-phase owner only advances when the bus accepts a phase.
      if (hready) begin
        hmaster   <= gidx;
        hmastlock <= hlock[gidx];
      end
    end
  end

endmodule
